// File: rtl/mastermind_pkg.sv
// rtl/mastermind_pkg.sv - shared constants and types for the mastermind button front end
// Contents: button bit positions within the 5-bit {S,R,L,U,D} vectors,
//           button count, per-channel FSM state type and a max helper.
package mastermind_pkg;

  localparam int NUM_BTNS = 5;

  localparam int BTN_S = 4;
  localparam int BTN_R = 3;
  localparam int BTN_L = 2;
  localparam int BTN_U = 1;
  localparam int BTN_D = 0;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_REPEAT   = 2'd2
  } btn_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button channel: synchronizer, debouncer, press/auto-repeat FSM
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   raw   - asynchronous raw button (1 = pressed)
//   level - debounced button level
//   press - one-cycle pulse on the debounced rise and on each auto-repeat
module btn_debounce
  import mastermind_pkg::*;
#(
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 15000000,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  // Debounce counter only ever needs to reach DB_CYCLES-1; keep at least one bit.
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int HOLD_MAX = max_of(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

  localparam logic [DBW-1:0] DB_LAST     = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0]  PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic s1, s2;
  logic [DBW-1:0] db_cnt, db_cnt_next;
  logic [HW-1:0]  hold_cnt, hold_cnt_next;
  logic           level_next, press_next;
  logic           rise, fall;
  btn_state_t     state, state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      db_cnt   <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      state    <= ST_RELEASED;
      hold_cnt <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      db_cnt   <= db_cnt_next;
      level    <= level_next;
      press    <= press_next;
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  always_comb begin
    db_cnt_next   = '0;
    level_next    = level;
    press_next    = 1'b0;
    state_next    = state;
    hold_cnt_next = hold_cnt;

    // Any agreement between s2 and level (including a one-cycle bounce) restarts the count.
    if (s2 != level) begin
      if (db_cnt == DB_LAST) begin
        level_next = ~level;
      end else begin
        db_cnt_next = db_cnt + 1'b1;
      end
    end

    rise = level_next & ~level;
    fall = level & ~level_next;

    case (state)
      ST_RELEASED: begin
        if (rise) begin
          state_next    = ST_HELD;
          press_next    = 1'b1;
          hold_cnt_next = '0;
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_next    = ST_RELEASED;
          hold_cnt_next = '0;
        end else if (REPEAT_EN) begin
          if (hold_cnt == DELAY_LAST) begin
            state_next    = ST_REPEAT;
            press_next    = 1'b1;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt + 1'b1;
          end
        end
      end
      ST_REPEAT: begin
        // A release wins over a repeat pulse due on the same edge.
        if (fall) begin
          state_next    = ST_RELEASED;
          hold_cnt_next = '0;
        end else if (hold_cnt == PERIOD_LAST) begin
          press_next    = 1'b1;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_next    = ST_RELEASED;
        hold_cnt_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/mastermind_buttons.sv
// rtl/mastermind_buttons.sv - five debounced board buttons with press pulses and U/D auto-repeat
// Ports:
//   clk                          - rising-edge clock
//   rst                          - synchronous active-high reset
//   btnS, btnR, btnL, btnU, btnD - raw asynchronous buttons (1 = pressed)
//   btn_level[4:0]               - debounced levels {S,R,L,U,D}
//   btn_press[4:0]               - one-cycle press/repeat pulses {S,R,L,U,D}
module mastermind_buttons
  import mastermind_pkg::*;
#(
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 15000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnS,
  input  logic       btnR,
  input  logic       btnL,
  input  logic       btnU,
  input  logic       btnD,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press
);

  logic [NUM_BTNS-1:0] raw;

  assign raw = {btnS, btnR, btnL, btnU, btnD};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    // Only the up/down buttons auto-repeat.
    btn_debounce #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN    ((i == BTN_U) || (i == BTN_D))
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

endmodule

// File: tb/tb_mastermind_buttons.sv
// tb/tb_mastermind_buttons.sv - directed self-checking bench for mastermind_buttons
module tb_mastermind_buttons;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnS, btnR, btnL, btnU, btnD;
  logic [4:0] btn_level;
  logic [4:0] btn_press;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  mastermind_buttons #(
    .DB_CYCLES    (4),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btnS     (btnS),
    .btnR     (btnR),
    .btnL     (btnL),
    .btnU     (btnU),
    .btnD     (btnD),
    .btn_level(btn_level),
    .btn_press(btn_press)
  );

  // Leaves inputs low and returns #1 after a posedge; the next posedge is edge 0.
  task automatic reset_dut();
    rst  = 1'b1;
    btnS = 1'b0; btnR = 1'b0; btnL = 1'b0; btnU = 1'b0; btnD = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    asserts++;
    if (btn_level !== 5'b0) begin
      fails++;
      $display("FAIL reset_level: got %b expected %b", btn_level, 5'b0);
    end
    asserts++;
    if (btn_press !== 5'b0) begin
      fails++;
      $display("FAIL reset_press: got %b expected %b", btn_press, 5'b0);
    end
  endtask

  // btnS held edges 0..19: pulse after edge 5, level high edges 5..24, no repeats.
  task automatic test_press_s();
    logic [4:0] exp_p, exp_l;
    reset_dut();
    for (int e = 0; e <= 28; e++) begin
      btnS = (e < 20);
      @(posedge clk); #1;
      exp_p = (e == 5) ? 5'b10000 : 5'b00000;
      exp_l = (e >= 5 && e < 25) ? 5'b10000 : 5'b00000;
      asserts++;
      if (btn_press !== exp_p) begin
        fails++;
        $display("FAIL press_s e=%0d: got %b expected %b", e, btn_press, exp_p);
      end
      asserts++;
      if (btn_level !== exp_l) begin
        fails++;
        $display("FAIL level_s e=%0d: got %b expected %b", e, btn_level, exp_l);
      end
    end
  endtask

  // btnU for 3 samples: nothing; then 4 samples: pulse after edge 5, fall after edge 9.
  task automatic test_short_pulse_u();
    logic [4:0] exp_p, exp_l;
    reset_dut();
    for (int e = 0; e <= 10; e++) begin
      btnU = (e < 3);
      @(posedge clk); #1;
      asserts++;
      if (btn_press !== 5'b0 || btn_level !== 5'b0) begin
        fails++;
        $display("FAIL short_u e=%0d: got press %b level %b expected 00000 00000", e, btn_press, btn_level);
      end
    end
    for (int e = 0; e <= 14; e++) begin
      btnU = (e < 4);
      @(posedge clk); #1;
      exp_p = (e == 5) ? 5'b00010 : 5'b00000;
      exp_l = (e >= 5 && e < 9) ? 5'b00010 : 5'b00000;
      asserts++;
      if (btn_press !== exp_p || btn_level !== exp_l) begin
        fails++;
        $display("FAIL min_u e=%0d: got press %b level %b expected %b %b", e, btn_press, btn_level, exp_p, exp_l);
      end
    end
  endtask

  // btnD held edges 0..29: pulses after 5,13,16,...,34; level falls after edge 35.
  task automatic test_repeat_d();
    logic [4:0] exp_p, exp_l;
    reset_dut();
    for (int e = 0; e <= 42; e++) begin
      btnD = (e < 30);
      @(posedge clk); #1;
      exp_p = ((e == 5) || (e >= 13 && e < 35 && ((e - 13) % 3) == 0)) ? 5'b00001 : 5'b00000;
      exp_l = (e >= 5 && e < 35) ? 5'b00001 : 5'b00000;
      asserts++;
      if (btn_press !== exp_p || btn_level !== exp_l) begin
        fails++;
        $display("FAIL repeat_d e=%0d: got press %b level %b expected %b %b", e, btn_press, btn_level, exp_p, exp_l);
      end
    end
  endtask

  // btnD released so that the fall lands on edge 16 where a repeat is due.
  task automatic test_release_priority();
    logic [4:0] exp_p, exp_l;
    reset_dut();
    for (int e = 0; e <= 22; e++) begin
      btnD = (e < 11);
      @(posedge clk); #1;
      exp_p = (e == 5 || e == 13) ? 5'b00001 : 5'b00000;
      exp_l = (e >= 5 && e < 16) ? 5'b00001 : 5'b00000;
      asserts++;
      if (btn_press !== exp_p || btn_level !== exp_l) begin
        fails++;
        $display("FAIL release_prio e=%0d: got press %b level %b expected %b %b", e, btn_press, btn_level, exp_p, exp_l);
      end
    end
  endtask

  // btnL 1,0,1,0 then high from edge 4 (held, no repeat): single pulse after edge 9.
  task automatic test_bounce_l();
    logic [4:0] exp_p, exp_l;
    reset_dut();
    for (int e = 0; e <= 26; e++) begin
      btnL = (e < 4) ? ((e % 2) == 0) : (e < 20);
      @(posedge clk); #1;
      exp_p = (e == 9) ? 5'b00100 : 5'b00000;
      exp_l = (e >= 9 && e < 25) ? 5'b00100 : 5'b00000;
      asserts++;
      if (btn_press !== exp_p || btn_level !== exp_l) begin
        fails++;
        $display("FAIL bounce_l e=%0d: got press %b level %b expected %b %b", e, btn_press, btn_level, exp_p, exp_l);
      end
    end
  endtask

  // btnR raised at edge 0, rst sampled high at edge 3: re-debounced, pulse after edge 9.
  task automatic test_reset_mid();
    logic [4:0] exp_p, exp_l;
    reset_dut();
    for (int e = 0; e <= 20; e++) begin
      btnR = (e < 13);
      rst  = (e == 3);
      @(posedge clk); #1;
      exp_p = (e == 9) ? 5'b01000 : 5'b00000;
      exp_l = (e >= 9 && e < 18) ? 5'b01000 : 5'b00000;
      asserts++;
      if (btn_press !== exp_p || btn_level !== exp_l) begin
        fails++;
        $display("FAIL reset_mid e=%0d: got press %b level %b expected %b %b", e, btn_press, btn_level, exp_p, exp_l);
      end
    end
    rst = 1'b0;
  endtask

  // btnS and btnD together: both pulse after edge 5 in the same cycle.
  task automatic test_simultaneous();
    logic [4:0] exp_p, exp_l;
    reset_dut();
    for (int e = 0; e <= 14; e++) begin
      btnS = (e < 6);
      btnD = (e < 6);
      @(posedge clk); #1;
      exp_p = (e == 5) ? 5'b10001 : 5'b00000;
      exp_l = (e >= 5 && e < 11) ? 5'b10001 : 5'b00000;
      asserts++;
      if (btn_press !== exp_p || btn_level !== exp_l) begin
        fails++;
        $display("FAIL simultaneous e=%0d: got press %b level %b expected %b %b", e, btn_press, btn_level, exp_p, exp_l);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    btnS = 1'b0; btnR = 1'b0; btnL = 1'b0; btnU = 1'b0; btnD = 1'b0;
    test_reset();
    test_press_s();
    test_short_pulse_u();
    test_repeat_d();
    test_release_priority();
    test_bounce_l();
    test_reset_mid();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/mastermind_buttons.md
MASTERMIND_BUTTONS -- requirements
Module: mastermind_buttons

Interface
REQ-001 Parameter: DB_CYCLES, default 1000000, number of consecutive samples that must disagree with the debounced level before it toggles (minimum 1).
REQ-002 Parameter: REPEAT_DELAY, default 50000000, hold time in cycles from the press pulse to the first auto-repeat pulse.
REQ-003 Parameter: REPEAT_PERIOD, default 15000000, cycles between subsequent auto-repeat pulses.
REQ-004 Port: clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 Port: rst, input, 1 bit, reset; synchronous and active-high.
REQ-006 Ports: btnS, btnR, btnL, btnU, btnD, each input, 1 bit, raw asynchronous board buttons (1 = pressed).
REQ-007 Port: btn_level, output, 5 bits, debounced levels, ordered {S,R,L,U,D}, so bit 4 = S and bit 0 = D.
REQ-008 Port: btn_press, output, 5 bits, one-cycle press/auto-repeat pulses, same ordering as btn_level.

Function
REQ-009 Each raw button SHALL pass through a 2-flop synchronizer; only the second flop output (s2) is used downstream.
REQ-010 Each channel SHALL hold a debounce counter that increments on every edge where s2 differs from btn_level, and clears to 0 on any edge where they agree.
REQ-011 On the edge where the counter equals DB_CYCLES-1 and s2 still differs, btn_level SHALL toggle and the counter SHALL clear.
  - Latency: if raw is first sampled high at edge E0 and held for at least DB_CYCLES samples, btn_level rises after edge E0+DB_CYCLES+1.
  - A raw pulse shorter than DB_CYCLES samples SHALL cause no change.
REQ-012 btn_press[i] SHALL be high for exactly one cycle, coinciding with the first cycle of btn_level[i] rising.
  - A falling level SHALL produce no pulse.
REQ-013 A per-channel FSM SHALL have three states:
  - RELEASED -> HELD on the level rise (press pulse issued);
  - HELD -> REPEAT when the hold counter reaches REPEAT_DELAY;
  - HELD or REPEAT -> RELEASED on the level fall.
REQ-014 Auto-repeat SHALL apply only to btnU and btnD.
  - The first repeat pulse SHALL occur REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles while still held.
  - Repeat pulses SHALL appear on btn_press.
  - Channels S, R and L SHALL stay in HELD with no repeats.
REQ-015 The hold/repeat counter SHALL clear on every state transition.
  - It SHALL be sized to hold max(REPEAT_DELAY, REPEAT_PERIOD) with no wrap.
  - The debounce counter SHALL be sized to hold DB_CYCLES-1.
REQ-016 Channels SHALL be fully independent; simultaneous presses SHALL yield pulses in the same cycle.
REQ-017 A bounce (one-cycle agreement) at any point during counting SHALL restart the count from 0.
REQ-018 A release occurring in the same cycle a repeat pulse is due SHALL suppress that pulse.
  - Rule: the level fall has priority over the repeat.

Reset
REQ-019 While rst = 1 at a clock edge, all of the following SHALL clear to 0:
  - synchronizer flops, counters, btn_level and btn_press;
  - all FSMs, which SHALL enter RELEASED.
REQ-020 Reset asserted mid-debounce or mid-hold SHALL discard all progress, and no pulse SHALL be emitted for that press.
REQ-021 A button held through reset release SHALL be re-debounced from scratch and pulse after DB_CYCLES+1 edges.

Structure
REQ-022 The shared package mastermind_pkg SHALL hold:
  - button index constants BTN_S=4, BTN_R=3, BTN_L=2, BTN_U=1, BTN_D=0;
  - the button-count constant NUM_BTNS=5.
REQ-023 A single-channel sub-module, btn_debounce, SHALL contain the synchronizer, debounce counter and FSM.
  - It SHALL take a repeat-enable parameter.
  - mastermind_buttons SHALL instantiate it five times.

Verification (DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-024 btnS high sampled from edge 0 and held for 20 cycles -> btn_press[4] pulses only after edge 5, btn_level[4] is high after edge 5, and no repeats occur.
REQ-025 btnU high for exactly 3 samples -> no pulse and btn_level stays 0. Then btnU high for exactly 4 samples -> one pulse after edge E0+5.
REQ-026 btnD held for 30 cycles from edge 0 -> btn_press[0] pulses after edges 5, 13, 16, 19, ..., and stops once btn_level[0] falls after edge 35.
REQ-027 btnL toggling 1,0,1,0 then stable high from edge 4 -> exactly one pulse, after edge 9.
REQ-028 btnR raised at edge 0 with rst pulsed at edge 3 -> no pulse before edge 9; btn_press[3] pulses after edge 9.
REQ-029 btnS and btnD raised at the same edge -> btn_press = 5'b10001 in a single cycle.
